// File: rtl/hc4_bus_pkg.sv
// Shared definitions for the HC4 asynchronous RAM bus master.
// Holds the bus-master state encoding, default bus geometry and
// default phase lengths. Also holds a helper that sizes the phase
// timer.
package hc4_bus_pkg;

  localparam int ADDR_W_DEF        = 8;
  localparam int DATA_W_DEF        = 4;
  localparam int SETUP_CYCLES_DEF  = 1;
  localparam int STROBE_CYCLES_DEF = 2;
  localparam int HOLD_CYCLES_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } bus_state_e;

  // Gives the counter width needed to hold (longest phase - 1).
  // The result is at least 1 bit.
  function automatic int timer_width(input int s, input int w, input int h);
    int m;
    m = s;
    if (w > m) m = w;
    if (h > m) m = h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter that times one bus phase.
// Ports:
//   clk, nrst - clock and asynchronous active-low reset
//   load      - load `value` (phase length - 1) into the counter
//   value     - reload value
//   done      - counter is zero: the current phase is in its last cycle
module bus_phase_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, so no block sees a half-updated value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/memory_bus_master.sv
// Clocked initiator for the HC4 4-bit asynchronous RAM bus.
// The block accepts one valid/ready request at a time. It then runs
// three phases: SETUP, then STROBE, then HOLD. After HOLD it returns a
// one-cycle response pulse.
// Ports:
//   clk, nrst               - clock and asynchronous active-low reset
//   req_valid/req_ready     - request handshake; accepted when both are high
//   req_write               - 1 = write, 0 = read
//   req_addr/req_wdata      - request address and write data
//   rsp_valid               - one-cycle completion pulse
//   rsp_rdata               - read data; held until the next read completes
//   address                 - RAM address (registered; held while idle)
//   data_bus                - shared tristate data bus
//   nwrite_enable           - active-low RAM write strobe
//   nread_enable            - active-low RAM read strobe
module memory_bus_master
  import hc4_bus_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETUP_CYCLES  = SETUP_CYCLES_DEF,
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              nwrite_enable,
  output logic              nread_enable
);

  localparam int TW = timer_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [TW-1:0] LOAD_SETUP  = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_STROBE = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] LOAD_HOLD   = TW'(HOLD_CYCLES - 1);

  bus_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_en_q;
  logic              accept;
  logic              timer_load;
  logic [TW-1:0]     timer_value;
  logic              timer_done;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid && req_ready;

  bus_phase_timer #(.WIDTH(TW)) u_timer (
    .clk   (clk),
    .nrst  (nrst),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // NOTE: every signal written here gets a default before the case statement.
  // A path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_load  = 1'b0;
    timer_value = LOAD_SETUP;
    write_d     = accept ? req_write : write_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_SETUP;
          timer_load = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_d     = ST_STROBE;
          timer_load  = 1'b1;
          timer_value = LOAD_STROBE;
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          state_d     = ST_HOLD;
          timer_load  = 1'b1;
          timer_value = LOAD_HOLD;
        end
      end
      ST_HOLD: begin
        if (timer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and the bus enable are flops fed from the next state. This
  // keeps them glitch-free and still lines them up with their phase. The
  // address and write data change only on accept, which happens in IDLE.
  // So they are stable across every strobe window.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      address       <= '0;
      drive_en_q    <= 1'b0;
      nwrite_enable <= 1'b1;
      nread_enable  <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        address <= req_addr;
        wdata_q <= req_wdata;
      end
      drive_en_q    <= (state_d != ST_IDLE) && write_d;
      nwrite_enable <= !((state_d == ST_STROBE) && write_d);
      nread_enable  <= !((state_d == ST_STROBE) && !write_d);
      rsp_valid     <= (state_q == ST_HOLD) && timer_done;
      // The edge that ends the last read-strobe cycle samples the bus.
      // The RAM is still driving the bus at this edge.
      if ((state_q == ST_STROBE) && timer_done && !write_q) begin
        rsp_rdata <= data_bus;
      end
    end
  end

  assign data_bus = drive_en_q ? wdata_q : {DATA_W{1'bz}};

endmodule
